// File: rtl/writeback_unit.sv
// writeback_unit: MEM->regfile writeback stage with load alignment, mem wait/timeout, forwarding and retire count
module writeback_unit #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_RegWrite,
    input  logic [REG_ADDR_W-1:0]       in_RegDest,
    input  logic [1:0]                  in_RegDataSrc,
    input  logic [1:0]                  in_LoadSize,
    input  logic                        in_LoadUnsigned,
    input  logic [$clog2(XLEN/8)-1:0]   in_ByteOff,
    input  logic [XLEN-1:0]             result_alu,
    input  logic [XLEN-1:0]             pc_plus4,
    input  logic [XLEN-1:0]             imm,
    input  logic                        mem_done,
    input  logic [XLEN-1:0]             data_mem,
    output logic                        rb_write_en,
    output logic [REG_ADDR_W-1:0]       rb_addr,
    output logic [XLEN-1:0]             data_wb,
    output logic                        fwd_valid,
    output logic [REG_ADDR_W-1:0]       fwd_rd,
    output logic [XLEN-1:0]             fwd_data,
    output logic                        mem_timeout,
    output logic [CNT_W-1:0]            retired
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t                state;
    logic [7:0]            tcnt;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            src_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [OFF_W-1:0]      off_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       pc4_q;
    logic [XLEN-1:0]       imm_q;
    logic [XLEN-1:0]       mem_q;
    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       load_ext;
    logic [XLEN-1:0]       sel;
    logic                  sign;
    int                    nbits;
    logic                  commit;
    logic                  accept;
    logic                  is_load;

    assign commit  = state == COMMIT;
    assign in_ready = state != WAIT_MEM;
    assign accept  = in_valid & in_ready;
    assign is_load = in_RegDataSrc == 2'b01;

    // Rotate the captured word right by whole bytes, then keep LoadSize bytes and extend
    always_comb begin
        shifted  = '0;
        load_ext = '0;
        nbits = (size_q == 2'd0) ? 8 : (size_q == 2'd1) ? 16 : (size_q == 2'd2) ? 32 : XLEN;
        for (int i = 0; i < NB; i++) shifted[8*i +: 8] = mem_q[8*((i + int'(off_q)) % NB) +: 8];
        sign = ~uns_q & ((size_q == 2'd0) ? shifted[7] : (size_q == 2'd1) ? shifted[15] :
                         (size_q == 2'd2) ? shifted[31] : shifted[XLEN-1]);
        for (int i = 0; i < XLEN; i++) load_ext[i] = (i < nbits) ? shifted[i] : sign;
    end

    assign sel = (src_q == 2'b00) ? alu_q : (src_q == 2'b01) ? load_ext :
                 (src_q == 2'b10) ? pc4_q : imm_q;

    assign rb_write_en = commit & we_q & (rd_q != '0);
    assign rb_addr     = commit ? rd_q : '0;
    assign data_wb     = commit ? sel : '0;
    assign fwd_valid   = rb_write_en;
    assign fwd_rd      = rb_addr;
    assign fwd_data    = data_wb;

    // Handshake FSM: capture on accept, wait for load data with timeout, retire after COMMIT or abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            src_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            mem_q       <= '0;
            mem_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            mem_timeout <= 1'b0;
            if (state == WAIT_MEM) begin
                tcnt <= tcnt + 8'd1;
                if (mem_done) begin
                    mem_q <= data_mem;
                    state <= COMMIT;
                end else if (tcnt == 8'(MEM_TIMEOUT - 1)) begin
                    mem_timeout <= 1'b1;
                    retired     <= retired + 1'b1;
                    state       <= IDLE;
                end
            end else begin
                if (commit) retired <= retired + 1'b1;
                if (accept) begin
                    we_q   <= in_RegWrite;
                    rd_q   <= in_RegDest;
                    src_q  <= in_RegDataSrc;
                    size_q <= in_LoadSize;
                    uns_q  <= in_LoadUnsigned;
                    off_q  <= in_ByteOff;
                    alu_q  <= result_alu;
                    pc4_q  <= pc_plus4;
                    imm_q  <= imm;
                    tcnt   <= '0;
                    if (is_load && mem_done) mem_q <= data_mem;
                    state <= (is_load && !mem_done) ? WAIT_MEM : COMMIT;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule
